// File: rtl/status_branch_sequencer_pkg.sv
// Shared definitions for the status-driven PC sequencer.
//   status_e : 3-bit {status2,status1,status0} code from the control decoder
//   state_e  : sequencer state (IDLE accepts steps, MEM waits for mem_ack)
package status_branch_sequencer_pkg;

  localparam int unsigned STATUS_W  = 3;
  localparam int unsigned JTARGET_W = 26;

  typedef enum logic [STATUS_W-1:0] {
    ST_NORM  = 3'b000,
    ST_BMN   = 3'b001,
    ST_BRZ   = 3'b010,
    ST_BZ    = 3'b011,
    ST_JMOR  = 3'b100,
    ST_JALM  = 3'b101,
    ST_JSPAL = 3'b110,
    ST_BEQ   = 3'b111
  } status_e;

  typedef enum logic {
    IDLE = 1'b0,
    MEM  = 1'b1
  } state_e;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational next-PC and memory-address candidates for the sequencer.
// Ports:
//   pc, imm_ext, jtarget, rs_val, sp_val : current PC and operand inputs
//   pc4_c         : pc+4
//   bt_c          : pc4 + (imm_ext << 2)
//   jt_c          : {pc4[top 4], jtarget, 2'b00}
//   rs_imm_addr_c : (rs_val + imm_ext), word aligned
//   rs_addr_c     : rs_val, word aligned
//   sp_addr_c     : sp_val, word aligned
module branch_target_calc
  import status_branch_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]    pc,
  input  logic [ADDR_W-1:0]    imm_ext,
  input  logic [JTARGET_W-1:0] jtarget,
  input  logic [ADDR_W-1:0]    rs_val,
  input  logic [ADDR_W-1:0]    sp_val,
  output logic [ADDR_W-1:0]    pc4_c,
  output logic [ADDR_W-1:0]    bt_c,
  output logic [ADDR_W-1:0]    jt_c,
  output logic [ADDR_W-1:0]    rs_imm_addr_c,
  output logic [ADDR_W-1:0]    rs_addr_c,
  output logic [ADDR_W-1:0]    sp_addr_c
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  logic [ADDR_W-1:0] rs_imm_sum;

  assign pc4_c         = pc + ADDR_W'(4);
  assign bt_c          = pc4_c + (imm_ext << 2);
  // Region-relative jump: keep the top nibble of pc4 above the 28-bit target.
  assign jt_c          = {pc4_c[ADDR_W-1:JTARGET_W+2], jtarget, 2'b00};
  assign rs_imm_sum    = rs_val + imm_ext;
  assign rs_imm_addr_c = rs_imm_sum & ALIGN_MASK;
  assign rs_addr_c     = rs_val & ALIGN_MASK;
  assign sp_addr_c     = sp_val & ALIGN_MASK;

endmodule

// File: rtl/status_branch_sequencer.sv
// Owns the architectural PC and resolves next-PC from the decoder status code,
// including flag branches and memory-indirect jumps run over a req/ack port.
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   step_valid, status        : decoded instruction and its 3-bit status code
//   imm_ext, jtarget          : immediate and J-format target
//   rs_val, sp_val            : register operands
//   alu_zero, alu_neg, flag_we: live ALU flags and Z/N latch enable
//   pc, busy                  : current PC, stall request
//   mem_req/we/addr/wdata     : data-memory request, held until mem_ack
//   mem_rdata, mem_ack        : read data and one-cycle completion
//   link_we, link_data        : one-cycle return-address write
module status_branch_sequencer
  import status_branch_sequencer_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 step_valid,
  input  logic [STATUS_W-1:0]  status,
  input  logic [ADDR_W-1:0]    imm_ext,
  input  logic [JTARGET_W-1:0] jtarget,
  input  logic [ADDR_W-1:0]    rs_val,
  input  logic [ADDR_W-1:0]    sp_val,
  input  logic                 alu_zero,
  input  logic                 alu_neg,
  input  logic                 flag_we,
  output logic [ADDR_W-1:0]    pc,
  output logic                 busy,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [ADDR_W-1:0]    mem_wdata,
  input  logic [ADDR_W-1:0]    mem_rdata,
  input  logic                 mem_ack,
  output logic                 link_we,
  output logic [ADDR_W-1:0]    link_data
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_e            state_q, state_d;
  status_e           op_q, op_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              z_q, z_d, n_q, n_d;
  logic              busy_q, busy_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              link_we_q, link_we_d;
  logic [ADDR_W-1:0] link_data_q, link_data_d;
  logic [ADDR_W-1:0] cap_pc4_q, cap_pc4_d;
  logic [ADDR_W-1:0] cap_jt_q, cap_jt_d;

  logic [ADDR_W-1:0] pc4_c, bt_c, jt_c, rs_imm_addr_c, rs_addr_c, sp_addr_c;
  status_e           status_c;

  assign status_c = status_e'(status);

  branch_target_calc #(.ADDR_W(ADDR_W)) u_calc (
    .pc            (pc_q),
    .imm_ext       (imm_ext),
    .jtarget       (jtarget),
    .rs_val        (rs_val),
    .sp_val        (sp_val),
    .pc4_c         (pc4_c),
    .bt_c          (bt_c),
    .jt_c          (jt_c),
    .rs_imm_addr_c (rs_imm_addr_c),
    .rs_addr_c     (rs_addr_c),
    .sp_addr_c     (sp_addr_c)
  );

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    pc_d        = pc_q;
    busy_d      = busy_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    link_we_d   = 1'b0;
    link_data_d = link_data_q;
    cap_pc4_d   = cap_pc4_q;
    cap_jt_d    = cap_jt_q;
    // Flags update at this edge; a step in the same cycle sees z_q/n_q.
    z_d         = flag_we ? alu_zero : z_q;
    n_d         = flag_we ? alu_neg  : n_q;

    unique case (state_q)
      IDLE: begin
        if (step_valid) begin
          unique case (status_c)
            ST_NORM: pc_d = pc4_c;
            ST_BEQ:  pc_d = alu_zero ? bt_c : pc4_c;
            ST_BRZ:  pc_d = z_q ? rs_addr_c : pc4_c;
            ST_BZ:   pc_d = z_q ? jt_c : pc4_c;
            ST_BMN, ST_JMOR, ST_JALM, ST_JSPAL: begin
              if (status_c == ST_BMN && !n_q) begin
                pc_d = pc4_c;
              end else begin
                state_d   = MEM;
                op_d      = status_c;
                busy_d    = 1'b1;
                mem_req_d = 1'b1;
                mem_we_d  = (status_c == ST_JSPAL);
                cap_pc4_d = pc4_c;
                cap_jt_d  = jt_c;
                unique case (status_c)
                  ST_JMOR:  mem_addr_d = rs_addr_c;
                  ST_JSPAL: begin
                    mem_addr_d  = sp_addr_c;
                    mem_wdata_d = pc4_c;
                  end
                  default:  mem_addr_d = rs_imm_addr_c;
                endcase
              end
            end
          endcase
        end
      end
      MEM: begin
        if (mem_ack) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          mem_req_d = 1'b0;
          pc_d      = (op_q == ST_JSPAL) ? cap_jt_q : (mem_rdata & ALIGN_MASK);
          if (op_q == ST_JMOR || op_q == ST_JALM) begin
            link_we_d   = 1'b1;
            link_data_d = cap_pc4_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= ST_NORM;
      pc_q        <= RESET_PC;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      link_we_q   <= 1'b0;
      link_data_q <= '0;
      cap_pc4_q   <= '0;
      cap_jt_q    <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      pc_q        <= pc_d;
      z_q         <= z_d;
      n_q         <= n_d;
      busy_q      <= busy_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      link_we_q   <= link_we_d;
      link_data_q <= link_data_d;
      cap_pc4_q   <= cap_pc4_d;
      cap_jt_q    <= cap_jt_d;
    end
  end

  assign pc        = pc_q;
  assign busy      = busy_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign link_we   = link_we_q;
  assign link_data = link_data_q;

endmodule

// File: tb/tb_status_branch_sequencer.sv
// Directed bench for status_branch_sequencer: PC stepping, flag branches,
// memory-indirect jumps, stall behaviour and reset abandoning a transaction.
module tb_status_branch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        step_valid;
  logic [2:0]  status;
  logic [31:0] imm_ext;
  logic [25:0] jtarget;
  logic [31:0] rs_val;
  logic [31:0] sp_val;
  logic        alu_zero;
  logic        alu_neg;
  logic        flag_we;
  logic [31:0] pc;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        link_we;
  logic [31:0] link_data;

  int checks   = 0;
  int failures = 0;

  status_branch_sequencer #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .step_valid (step_valid),
    .status     (status),
    .imm_ext    (imm_ext),
    .jtarget    (jtarget),
    .rs_val     (rs_val),
    .sp_val     (sp_val),
    .alu_zero   (alu_zero),
    .alu_neg    (alu_neg),
    .flag_we    (flag_we),
    .pc         (pc),
    .busy       (busy),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .link_we    (link_we),
    .link_data  (link_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [2:0] st);
    step_valid = 1'b1;
    status     = st;
    tick();
    step_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; step_valid = 1'b0; status = 3'b000; imm_ext = '0; jtarget = '0;
    rs_val = '0; sp_val = '0; alu_zero = 1'b0; alu_neg = 1'b0; flag_we = 1'b0;
    mem_rdata = '0; mem_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_pc", pc, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_link_we", 32'(link_we), 32'h0);
    chk("rst_link_data", link_data, 32'h0);

    // Sequential stepping
    step(3'b000); chk("norm1_pc", pc, 32'h4); chk("norm1_busy", 32'(busy), 32'h0);
    step(3'b000); chk("norm2_pc", pc, 32'h8);
    step(3'b000); chk("norm3_pc", pc, 32'hC); chk("norm3_busy", 32'(busy), 32'h0);
    tick(); chk("hold_pc", pc, 32'hC);

    // Latch Z=1, then brz and bz
    flag_we = 1'b1; alu_zero = 1'b1; tick(); flag_we = 1'b0; alu_zero = 1'b0;
    rs_val = 32'h2003; step(3'b010); chk("brz_pc", pc, 32'h2000);
    jtarget = 26'h40; step(3'b011); chk("bz_taken_pc", pc, 32'h100);

    // beq taken / not taken
    imm_ext = 32'hFFFF_FFFE; alu_zero = 1'b1; step(3'b111); alu_zero = 1'b0;
    chk("beq_taken_pc", pc, 32'hFC);
    step(3'b011); chk("bz_back_pc", pc, 32'h100);
    alu_zero = 1'b0; step(3'b111); chk("beq_nt_pc", pc, 32'h104);

    // Clear Z, then flag_we together with bz uses old Z=0
    flag_we = 1'b1; alu_zero = 1'b0; tick();
    alu_zero = 1'b1; jtarget = 26'h10; step(3'b011); flag_we = 1'b0; alu_zero = 1'b0;
    chk("bz_same_cycle_pc", pc, 32'h108);
    step(3'b011); chk("bz_new_z_pc", pc, 32'h40);

    // jalm with ack after 3 cycles; step_valid during busy is ignored
    rs_val = 32'h1000; imm_ext = 32'h8; step(3'b101);
    chk("jalm_busy0", 32'(busy), 32'h1);
    chk("jalm_req0", 32'(mem_req), 32'h1);
    chk("jalm_we0", 32'(mem_we), 32'h0);
    chk("jalm_addr0", mem_addr, 32'h1008);
    chk("jalm_pc0", pc, 32'h40);
    step_valid = 1'b1; status = 3'b000; rs_val = 32'h0; imm_ext = 32'h0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("jalm_busy", 32'(busy), 32'h1);
      chk("jalm_addr", mem_addr, 32'h1008);
      chk("jalm_pc_stall", pc, 32'h40);
    end
    mem_ack = 1'b1; mem_rdata = 32'h500; tick();
    mem_ack = 1'b0; step_valid = 1'b0;
    chk("jalm_pc", pc, 32'h500);
    chk("jalm_busy_done", 32'(busy), 32'h0);
    chk("jalm_req_done", 32'(mem_req), 32'h0);
    chk("jalm_link_we", 32'(link_we), 32'h1);
    chk("jalm_link_data", link_data, 32'h44);
    tick();
    chk("jalm_link_we_off", 32'(link_we), 32'h0);
    chk("jalm_pc_hold", pc, 32'h500);

    // bmn with N=0 is a plain step
    rs_val = 32'h200; imm_ext = 32'h7; step(3'b001);
    chk("bmn_n0_pc", pc, 32'h504);
    chk("bmn_n0_req", 32'(mem_req), 32'h0);
    // bmn with N=1 reads at aligned rs+imm
    flag_we = 1'b1; alu_neg = 1'b1; tick(); flag_we = 1'b0; alu_neg = 1'b0;
    step(3'b001);
    chk("bmn_req", 32'(mem_req), 32'h1);
    chk("bmn_addr", mem_addr, 32'h204);
    mem_ack = 1'b1; mem_rdata = 32'h603; tick(); mem_ack = 1'b0;
    chk("bmn_pc", pc, 32'h600);
    chk("bmn_no_link", 32'(link_we), 32'h0);

    // Stray ack while idle
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; tick(); mem_ack = 1'b0;
    chk("stray_ack_pc", pc, 32'h600);
    chk("stray_ack_busy", 32'(busy), 32'h0);

    // Reach 0x3FFF_FFF8 via bmn (N still 1), then jspal
    rs_val = 32'h300; imm_ext = 32'h0; step(3'b001);
    mem_ack = 1'b1; mem_rdata = 32'h3FFF_FFF8; tick(); mem_ack = 1'b0;
    chk("bmn2_pc", pc, 32'h3FFF_FFF8);
    sp_val = 32'h7FFC; jtarget = 26'h10; step(3'b110);
    chk("jspal_req", 32'(mem_req), 32'h1);
    chk("jspal_we", 32'(mem_we), 32'h1);
    chk("jspal_addr", mem_addr, 32'h7FFC);
    chk("jspal_wdata", mem_wdata, 32'h3FFF_FFFC);
    tick();
    chk("jspal_wdata_hold", mem_wdata, 32'h3FFF_FFFC);
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    chk("jspal_pc", pc, 32'h3000_0040);
    chk("jspal_no_link", 32'(link_we), 32'h0);
    chk("jspal_req_done", 32'(mem_req), 32'h0);

    // jmor abandoned by reset; late ack ignored
    rs_val = 32'h1234; step(3'b100);
    chk("jmor_req", 32'(mem_req), 32'h1);
    chk("jmor_addr", mem_addr, 32'h1234);
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("jmor_rst_req", 32'(mem_req), 32'h0);
    chk("jmor_rst_pc", pc, 32'h0);
    chk("jmor_rst_link", 32'(link_we), 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h999; tick(); mem_ack = 1'b0;
    chk("late_ack_pc", pc, 32'h0);
    chk("late_ack_link", 32'(link_we), 32'h0);
    chk("late_ack_busy", 32'(busy), 32'h0);
    tick();
    chk("late_ack_link2", 32'(link_we), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
